// File: rtl/uart_mux_pkg.sv
// Constants shared by the UART mux scheduler, the TX demux and the host-side decoder.
// Defines the tag/escape bytes, the channel index width and the scheduler state encoding.
package uart_mux_pkg;

    localparam int CH_BITS = 3;

    localparam logic [7:0] TAG_BASE = 8'hF0;
    localparam logic [7:0] ESC_BYTE = 8'hFE;

    typedef enum logic [1:0] {
        S_ARB  = 2'd0,
        S_TAG  = 2'd1,
        S_DATA = 2'd2,
        S_ESC  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/uart_rx_scheduler_rr_pick.sv
// Combinational round-robin selector: first requester after 'last', wrapping modulo UART_COUNT.
// Shared with the TX demux, so it carries no state of its own.
module rr_pick
    import uart_mux_pkg::*;
#(
    parameter int UART_COUNT = 4
) (
    input  logic [UART_COUNT-1:0] req,
    input  logic [CH_BITS-1:0]    last,
    output logic                  found,
    output logic [CH_BITS-1:0]    idx
);

    logic [7:0] req_pad;
    logic [3:0] cand;

    assign req_pad = 8'(req);

    // Wrap is an explicit subtract so non-power-of-two channel counts rotate correctly.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= UART_COUNT; k++) begin
            cand = {1'b0, last} + 4'(k);
            if (cand >= 4'(UART_COUNT)) begin
                cand = cand - 4'(UART_COUNT);
            end
            if (!found && req_pad[cand[2:0]]) begin
                found = 1'b1;
                idx   = cand[2:0];
            end
        end
    end

endmodule

// File: rtl/uart_rx_scheduler.sv
// Drains UART_COUNT first-word-fall-through RX FIFOs into one USB TX FIFO as a tagged,
// escaped byte stream. Pushes and pops are combinational so a push costs no extra cycle.
module uart_rx_scheduler
    import uart_mux_pkg::*;
#(
    parameter int UART_COUNT = 4,
    parameter int BURST_MAX  = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            resync,
    input  logic [UART_COUNT-1:0]           empty,
    input  logic [UART_COUNT*DATA_BITS-1:0] data,
    output logic [UART_COUNT-1:0]           read,
    input  logic                            out_fifo_full,
    output logic                            out_fifo_write,
    output logic [7:0]                      out_fifo_data,
    output logic [CH_BITS-1:0]              grant,
    output logic                            busy
);

    sched_state_e       state_q, state_d;
    logic [CH_BITS-1:0] grant_q, grant_d;
    logic [CH_BITS-1:0] last_q, last_d;
    logic [CH_BITS-1:0] cur_ch_q, cur_ch_d;
    logic               tag_valid_q, tag_valid_d;
    logic               resync_pend_q, resync_pend_d;
    logic [7:0]         count_q, count_d;

    logic               pick_found;
    logic [CH_BITS-1:0] pick_idx;
    logic [63:0]        data_pad;
    logic [7:0]         empty_pad;
    logic [7:0]         head;
    logic               head_empty;
    logic [7:0]         count_inc;
    logic               last_beat;
    logic               pend_eff;

    rr_pick #(
        .UART_COUNT(UART_COUNT)
    ) u_rr_pick (
        .req  (~empty),
        .last (last_q),
        .found(pick_found),
        .idx  (pick_idx)
    );

    // Pad to the 8-channel maximum; absent channels read as permanently empty.
    assign data_pad   = 64'(data);
    assign empty_pad  = ~8'(~empty);
    assign head       = data_pad[{grant_q, 3'b000} +: 8];
    assign head_empty = empty_pad[grant_q];
    assign count_inc  = count_q + 8'd1;
    assign last_beat  = (count_inc == 8'(BURST_MAX));
    assign pend_eff   = resync_pend_q | resync;

    assign grant = grant_q;
    assign busy  = (state_q != S_ARB);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_ARB;
            grant_q       <= '0;
            last_q        <= CH_BITS'(UART_COUNT - 1);
            cur_ch_q      <= '0;
            tag_valid_q   <= 1'b0;
            resync_pend_q <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            cur_ch_q      <= cur_ch_d;
            tag_valid_q   <= tag_valid_d;
            resync_pend_q <= resync_pend_d;
            count_q       <= count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        cur_ch_d       = cur_ch_q;
        tag_valid_d    = tag_valid_q;
        resync_pend_d  = pend_eff;
        count_d        = count_q;
        out_fifo_write = 1'b0;
        out_fifo_data  = 8'h00;
        read           = '0;

        unique case (state_q)
            S_ARB: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    count_d = '0;
                    if (tag_valid_q && (pick_idx == cur_ch_q) && !pend_eff) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_TAG;
                    end
                end
            end
            S_TAG: begin
                if (!out_fifo_full) begin
                    out_fifo_write = 1'b1;
                    out_fifo_data  = TAG_BASE | 8'(grant_q);
                    cur_ch_d       = grant_q;
                    tag_valid_d    = 1'b1;
                    // A pulse arriving on the tag cycle itself is kept for the next decision.
                    resync_pend_d  = resync;
                    state_d        = S_DATA;
                end
            end
            S_DATA: begin
                if (head_empty) begin
                    state_d = S_ARB;
                    last_d  = grant_q;
                end else if (!out_fifo_full) begin
                    out_fifo_write = 1'b1;
                    if (head >= TAG_BASE) begin
                        out_fifo_data = ESC_BYTE;
                        state_d       = S_ESC;
                    end else begin
                        out_fifo_data = head;
                        read          = UART_COUNT'(1) << grant_q;
                        count_d       = count_inc;
                        if (last_beat) begin
                            state_d = S_ARB;
                            last_d  = grant_q;
                        end
                    end
                end
            end
            S_ESC: begin
                if (!out_fifo_full) begin
                    out_fifo_write = 1'b1;
                    out_fifo_data  = head;
                    read           = UART_COUNT'(1) << grant_q;
                    count_d        = count_inc;
                    if (last_beat) begin
                        state_d = S_ARB;
                        last_d  = grant_q;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            default: state_d = S_ARB;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_scheduler.sv
// Directed bench for uart_rx_scheduler: models the RX FIFOs, logs every accepted push
// and compares the logged stream against hand-written expected byte sequences.
module tb_uart_rx_scheduler;

    localparam int NCH = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             resync;
    logic [NCH-1:0]   empty;
    logic [NCH*8-1:0] data;
    logic [NCH-1:0]   read;
    logic             out_fifo_full;
    logic             out_fifo_write;
    logic [7:0]       out_fifo_data;
    logic [2:0]       grant;
    logic             busy;

    uart_rx_scheduler #(
        .UART_COUNT(NCH),
        .BURST_MAX (16),
        .DATA_BITS (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .resync        (resync),
        .empty         (empty),
        .data          (data),
        .read          (read),
        .out_fifo_full (out_fifo_full),
        .out_fifo_write(out_fifo_write),
        .out_fifo_data (out_fifo_data),
        .grant         (grant),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] fq [NCH][$];
    logic [7:0] out_log[$];
    logic [7:0] rd_log[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_rd[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NCH; i++) begin
            empty[i]       = (fq[i].size() == 0);
            data[8*i +: 8] = (fq[i].size() == 0) ? 8'h00 : fq[i][0];
        end
    endtask

    task automatic push(input int ch, input logic [7:0] b);
        fq[ch].push_back(b);
        refresh();
    endtask

    task automatic clear_logs();
        out_log.delete();
        rd_log.delete();
        exp_q.delete();
        exp_rd.delete();
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic [7:0] rd);
        exp_q.push_back(b);
        exp_rd.push_back(rd);
    endtask

    // One clock: sample outputs mid-cycle, then apply the pops the DUT issued.
    task automatic step();
        logic [NCH-1:0] rd_s;
        @(negedge clk);
        rd_s = read;
        if (read != '0) begin
            chk("rd_needs_wr", 32'(out_fifo_write), 32'd1);
            chk("rd_onehot", 32'($countones(read)), 32'd1);
        end
        if (out_fifo_full) begin
            chk("wr_while_full", 32'(out_fifo_write), 32'd0);
            chk("rd_while_full", 32'(read), 32'd0);
        end
        if (!out_fifo_write) chk("idle_data_zero", 32'(out_fifo_data), 32'd0);
        if (out_fifo_write && !out_fifo_full) begin
            out_log.push_back(out_fifo_data);
            rd_log.push_back(8'(read));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (rd_s[i]) begin
                if (fq[i].size() == 0) chk($sformatf("pop_empty_ch%0d", i), 32'd1, 32'd0);
                else void'(fq[i].pop_front());
            end
        end
        refresh();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_len"}, 32'(out_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < out_log.size()) begin
                chk($sformatf("%s_b%0d", tag, i), 32'(out_log[i]), 32'(exp_q[i]));
                chk($sformatf("%s_rd%0d", tag, i), 32'(rd_log[i]), 32'(exp_rd[i]));
            end
        end
    endtask

    initial begin
        int sz;
        reset_n       = 1'b0;
        resync        = 1'b0;
        out_fifo_full = 1'b0;
        refresh();
        #1;
        chk("rst_write", 32'(out_fifo_write), 32'd0);
        chk("rst_data", 32'(out_fifo_data), 32'd0);
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single byte on ch2 after reset: tag first, pop coincident with the data push.
        clear_logs();
        push(2, 8'h41);
        steps(8);
        expect_byte(8'hF2, 8'h00);
        expect_byte(8'h41, 8'h04);
        compare_logs("t1");
        chk("t1_ch2_drained", 32'(fq[2].size()), 32'd0);

        // Escaped byte on ch0: FE carries no pop, the escaped byte does.
        clear_logs();
        push(0, 8'hF5);
        steps(8);
        expect_byte(8'hF0, 8'h00);
        expect_byte(8'hFE, 8'h00);
        expect_byte(8'hF5, 8'h01);
        compare_logs("t2");

        // Burst limit: ch1 is cut at 16, ch3 gets its turn, ch1 resumes under a fresh tag.
        clear_logs();
        for (int i = 0; i < 20; i++) push(1, 8'(8'h10 + i));
        push(3, 8'h77);
        steps(40);
        expect_byte(8'hF1, 8'h00);
        for (int i = 0; i < 16; i++) expect_byte(8'(8'h10 + i), 8'h02);
        expect_byte(8'hF3, 8'h00);
        expect_byte(8'h77, 8'h08);
        expect_byte(8'hF1, 8'h00);
        for (int i = 16; i < 20; i++) expect_byte(8'(8'h10 + i), 8'h02);
        compare_logs("t3");

        // Back-pressure mid-burst; ch1 is still the tagged channel so no tag is repeated.
        clear_logs();
        for (int i = 0; i < 8; i++) push(1, 8'(8'hA0 + i));
        steps(3);
        sz = out_log.size();
        out_fifo_full = 1'b1;
        steps(5);
        chk("t4_stall_no_push", 32'(out_log.size()), 32'(sz));
        chk("t4_stall_no_pop", 32'(fq[1].size()), 32'(8 - sz));
        out_fifo_full = 1'b0;
        steps(12);
        for (int i = 0; i < 8; i++) expect_byte(8'(8'hA0 + i), 8'h02);
        compare_logs("t4");

        // Two ch0 bursts share one tag; a resync pulse forces the tag again.
        clear_logs();
        push(0, 8'h01);
        push(0, 8'h02);
        steps(8);
        push(0, 8'h03);
        steps(8);
        resync = 1'b1;
        step();
        resync = 1'b0;
        push(0, 8'h04);
        steps(8);
        expect_byte(8'hF0, 8'h00);
        expect_byte(8'h01, 8'h01);
        expect_byte(8'h02, 8'h01);
        expect_byte(8'h03, 8'h01);
        expect_byte(8'hF0, 8'h00);
        expect_byte(8'h04, 8'h01);
        compare_logs("t5");

        // Reset while in S_ESC: outputs drop at once, byte survives, stream restarts with a tag.
        clear_logs();
        push(0, 8'hF9);
        steps(2);
        chk("t6_esc_prefix", 32'(out_log.size() > 0 ? out_log[0] : 8'h00), 32'hFE);
        chk("t6_esc_write", 32'(out_fifo_write), 32'd1);
        chk("t6_esc_data", 32'(out_fifo_data), 32'hF9);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_rst_write", 32'(out_fifo_write), 32'd0);
        chk("t6_rst_data", 32'(out_fifo_data), 32'd0);
        chk("t6_rst_read", 32'(read), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        steps(2);
        chk("t6_head_kept", 32'(fq[0].size()), 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        clear_logs();
        steps(10);
        expect_byte(8'hF0, 8'h00);
        expect_byte(8'hFE, 8'h00);
        expect_byte(8'hF9, 8'h01);
        compare_logs("t6");
        chk("t6_ch0_drained", 32'(fq[0].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
